// File: rtl/uart_link_pkg.sv
// Shared constants and state types for the serial link frame receiver.
package uart_link_pkg;

    localparam int          DEF_CLK_DIV      = 2500;
    localparam int          DEF_TIMEOUT_BITS = 24;
    localparam logic [31:0] DEF_HEADER       = 32'hAA070200;

    // Header bytes in arrival order (MSB byte first on the wire).
    localparam logic [7:0]  HDR_B0 = DEF_HEADER[31:24];
    localparam logic [7:0]  HDR_B1 = DEF_HEADER[23:16];
    localparam logic [7:0]  HDR_B2 = DEF_HEADER[15:8];
    localparam logic [7:0]  HDR_B3 = DEF_HEADER[7:0];

    // Four header bytes plus a two-byte payload.
    localparam int          FRAME_LEN = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } byte_state_t;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        HDR2,
        HDR3,
        PAY_HI,
        PAY_LO
    } frame_state_t;

    // Pick header byte idx (0 = first on the wire) out of a packed header word.
    function automatic logic [7:0] hdr_byte(input logic [31:0] hdr, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = hdr[31:24];
            2'd1:    b = hdr[23:16];
            2'd2:    b = hdr[15:8];
            default: b = hdr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte de-serialiser: input synchroniser, start/data/stop bit timing,
// registered one-clock strobes for a good byte or a bad stop bit.
module uart_rx_byte
    import uart_link_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_rx,
    output logic       byte_strobe,
    output logic [7:0] byte_data,
    output logic       stop_err,
    output logic       start_det,
    output logic       rx_idle
);

    localparam int             CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLK_DIV - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_rx_prev;
    byte_state_t   r_state;
    byte_state_t   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          r_strobe;
    logic          w_strobe_next;
    logic          r_stop_err;
    logic          w_stop_err_next;
    logic          w_fall;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= line_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall = r_rx_prev & ~r_sync2;

    // State register and bit-timing datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_strobe   <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_bit      <= w_bit_next;
            r_shift    <= w_shift_next;
            r_strobe   <= w_strobe_next;
            r_stop_err <= w_stop_err_next;
        end
    end

    // Next-state logic: mid-bit sampling, LSB-first shift, stop-bit verdict.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt + CW'(1);
        w_bit_next      = r_bit;
        w_shift_next    = r_shift;
        w_strobe_next   = 1'b0;
        w_stop_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_fall) begin
                    w_state_next = S_START;
                    w_bit_next   = '0;
                end
            end
            S_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next   = '0;
                    // A line back high at mid start bit was only a glitch.
                    w_state_next = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next   = '0;
                    w_shift_next = {r_sync2, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next = '0;
                    // Back to idle at mid stop bit so the next start edge,
                    // half a bit later, is already watched for.
                    w_state_next    = S_IDLE;
                    w_strobe_next   = r_sync2;
                    w_stop_err_next = ~r_sync2;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign byte_strobe = r_strobe;
    assign byte_data   = r_shift;
    assign stop_err    = r_stop_err;
    assign start_det   = (r_state == S_IDLE) && w_fall;
    assign rx_idle     = (r_state == S_IDLE);

endmodule

// File: rtl/uart_rx_frame.sv
// Link frame receiver: checks the 4-byte header, collects the 16-bit payload,
// aborts on stop-bit errors, header mismatches and inter-byte timeouts.
module uart_rx_frame
    import uart_link_pkg::*;
#(
    parameter int          CLK_DIV      = DEF_CLK_DIV,
    parameter logic [31:0] HEADER       = DEF_HEADER,
    parameter int          TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_rx,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int            TO_CLKS = TIMEOUT_BITS * CLK_DIV;
    localparam int            TW      = $clog2(TO_CLKS + 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TO_CLKS - 1);

    logic         w_strobe;
    logic [7:0]   w_byte;
    logic         w_stop_err;
    logic         w_start_det;
    logic         w_rx_idle;
    logic         w_timeout;
    logic [7:0]   w_exp;

    frame_state_t r_state;
    frame_state_t w_state_next;
    logic [7:0]   r_pay_hi;
    logic [7:0]   w_pay_hi_next;
    logic [15:0]  r_data_out;
    logic [15:0]  w_data_out_next;
    logic         r_data_valid;
    logic         w_data_valid_next;
    logic         r_frame_err;
    logic         w_frame_err_next;
    logic         r_busy;
    logic [TW-1:0] r_to_cnt;

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_byte (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_rx     (line_rx),
        .byte_strobe (w_strobe),
        .byte_data   (w_byte),
        .stop_err    (w_stop_err),
        .start_det   (w_start_det),
        .rx_idle     (w_rx_idle)
    );

    // Inter-byte gap counter: runs only mid-frame while no byte is arriving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_start_det || (r_state == HDR0) || w_timeout) begin
            r_to_cnt <= '0;
        end else if (w_rx_idle) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign w_timeout = (r_state != HDR0) && w_rx_idle && (r_to_cnt == TO_M1);

    // Frame state, payload capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= HDR0;
            r_pay_hi     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pay_hi     <= w_pay_hi_next;
            r_data_out   <= w_data_out_next;
            r_data_valid <= w_data_valid_next;
            r_frame_err  <= w_frame_err_next;
            // Busy covers any byte in flight and any partially received frame.
            r_busy       <= (w_state_next != HDR0) || !w_rx_idle;
        end
    end

    // Expected header byte for the current position.
    always_comb begin
        w_exp = 8'h00;
        case (r_state)
            HDR0:    w_exp = hdr_byte(HEADER, 2'd0);
            HDR1:    w_exp = hdr_byte(HEADER, 2'd1);
            HDR2:    w_exp = hdr_byte(HEADER, 2'd2);
            HDR3:    w_exp = hdr_byte(HEADER, 2'd3);
            default: w_exp = 8'h00;
        endcase
    end

    // Frame next-state: only one event is acted on per clock, so an error
    // pulse and a valid pulse can never coincide.
    always_comb begin
        w_state_next      = r_state;
        w_pay_hi_next     = r_pay_hi;
        w_data_out_next   = r_data_out;
        w_data_valid_next = 1'b0;
        w_frame_err_next  = 1'b0;
        if (w_stop_err) begin
            w_frame_err_next = 1'b1;
            w_state_next     = HDR0;
        end else if (w_strobe) begin
            case (r_state)
                HDR0: begin
                    // Non-matching traffic while hunting is ignored silently.
                    if (w_byte == w_exp) begin
                        w_state_next = HDR1;
                    end
                end
                HDR1, HDR2, HDR3: begin
                    if (w_byte == w_exp) begin
                        w_state_next = (r_state == HDR1) ? HDR2 :
                                       (r_state == HDR2) ? HDR3 : PAY_HI;
                    end else begin
                        w_frame_err_next = 1'b1;
                        // A stray first-header byte may begin a new frame.
                        w_state_next = (w_byte == hdr_byte(HEADER, 2'd0)) ? HDR1 : HDR0;
                    end
                end
                PAY_HI: begin
                    w_pay_hi_next = w_byte;
                    w_state_next  = PAY_LO;
                end
                PAY_LO: begin
                    w_data_out_next   = {r_pay_hi, w_byte};
                    w_data_valid_next = 1'b1;
                    w_state_next      = HDR0;
                end
                default: w_state_next = HDR0;
            endcase
        end else if (w_timeout) begin
            w_frame_err_next = 1'b1;
            w_state_next     = HDR0;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Serial receiver for the fixed 6-byte link frame produced by the board's UART transmit stage. The frame is the 4-byte header AA 07 02 00 followed by a 16-bit payload, sent high byte first. The block de-serialises 8N1 bytes from line_rx at CLK_DIV clocks per bit and checks the header. On a good frame it presents the payload as a single-cycle valid pulse to downstream logic (display/control).

Parameters:
CLK_DIV, 2500, system clocks per bit period (matches the transmit-side divider).
HEADER, 32'hAA070200, expected header bytes, MSB byte received first.
TIMEOUT_BITS, 24, bit periods allowed between consecutive bytes of one frame before the frame is aborted.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
line_rx  in  1  asynchronous serial input, idle high
data_out  out  16  last good payload; {byte4, byte5}; holds until the next good frame
data_valid  out  1  one-clock pulse when data_out is updated
frame_err  out  1  one-clock pulse on stop-bit error, header mismatch or inter-byte timeout
busy  out  1  high from first header-byte start bit until frame end or abort

Behaviour:
- Reset: sampled only on a clk edge with rst_n=0. data_out=16'h0000, data_valid=0, frame_err=0, busy=0. Synchroniser flops=1, both FSMs in IDLE/HDR0, all counters 0. Reset mid-byte or mid-frame discards everything received so far.
- Input: line_rx passes through a 2-flop synchroniser. A start is a 1->0 transition on the synchronised signal.
- Byte FSM (sub-module), states IDLE, START, DATA, STOP:
  - IDLE -> START on a falling edge; the bit counter is cleared.
  - START: wait CLK_DIV/2-1 clocks, then sample. If the sample is 1 it was a glitch -> IDLE, with no strobe. If 0 -> DATA.
  - DATA: sample every CLK_DIV clocks, 8 samples, LSB first, shifted into the byte register.
  - STOP: sample after CLK_DIV clocks. A 1 gives byte_strobe=1 for one clock. A 0 gives stop_err=1 for one clock. Either way -> IDLE in the same cycle, so the next start bit can be detected half a bit later. This allows back-to-back bytes with zero or one idle bit.
- Frame FSM, states HDR0, HDR1, HDR2, HDR3, PAY_HI, PAY_LO:
  - Each byte_strobe compares the byte with the expected header byte, or stores it in PAY_HI/PAY_LO.
  - Header mismatch: frame_err pulse. If the bad byte is 8'hAA -> HDR1 (resync); otherwise -> HDR0.
  - A mismatch in HDR0 itself is not an error; stay in HDR0 silently (line noise/idle traffic).
  - PAY_LO strobe: next clock data_out <= {hi, lo} and data_valid=1, then -> HDR0.
  - stop_err in any state: frame_err pulse, -> HDR0.
- Timeout:
  - An inter-byte counter runs while the frame FSM is not in HDR0 and the byte FSM is IDLE.
  - On reaching TIMEOUT_BITS*CLK_DIV clocks: frame_err pulse, -> HDR0.
  - The counter is cleared on every start detect.
- Latency: data_valid rises 1 clock after the mid-stop-bit sample of the 6th byte. That is 2 (sync) + 1 (strobe) + 1 (register) clocks after the ideal mid-stop instant.
- Simultaneous events: the frame_err pulse and data_valid are never asserted in the same cycle. A new frame's start bit arriving while data_valid is being asserted is handled normally.
- Width rules: the bit-timing counter is $clog2(CLK_DIV) bits wide; the timeout counter is wide enough for TIMEOUT_BITS*CLK_DIV.

Decomposition:
- Shared package uart_link_pkg: HEADER bytes (HDR_B0..HDR_B3), the default CLK_DIV, the frame length constant (6), and the frame-FSM state enum.
- One sub-module, uart_rx_byte: synchroniser, byte FSM, and the outputs byte_strobe / byte_data[7:0] / stop_err.
- uart_rx_frame instantiates it and holds the frame FSM, timeout counter and output registers.

Test Plan:
- Reset: hold rst_n=0 for 5 clocks while line_rx toggles -> all outputs 0, no pulses. Release, idle 2 bit times -> still quiet.
- Good frame: AA 07 02 00 12 34 with one idle bit between bytes (CLK_DIV=2500) -> exactly one data_valid pulse; data_out=16'h1234; frame_err never high; busy falls with valid.
- Header resync: AA 07 AA 07 02 00 BE EF -> one frame_err at the 3rd byte, then data_valid with data_out=16'hBEEF.
- Bad stop bit: good header, payload hi byte sent with stop=0 -> frame_err pulse; no data_valid; data_out keeps the previous value (16'h1234).
- Timeout and glitch:
  - Send AA 07, then stay idle 30 bit times -> frame_err pulse at 24 bits and busy=0. A following full frame with payload 0001 -> data_valid with 16'h0001.
  - A 100-clock low glitch on line_rx in idle -> no strobe, no error.
- Reset mid-frame: assert rst_n=0 for 1 clock during payload byte 1, then send a full frame with payload 5A5A -> exactly one data_valid, data_out=16'h5A5A.
